// File: rtl/seq_divider_8bit_pkg.sv
// seq_divider_8bit_pkg: shared types and constants for the sequential divider
//   div_state_t       : FSM states IDLE / CALC / DONE
//   DIV_WIDTH_DEFAULT : default operand width
//   DIV_CNT_W_DEFAULT : step-counter width matching the default operand width
package div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
    localparam int DIV_WIDTH_DEFAULT = 8;
    localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT);
endpackage

// File: rtl/seq_divider_8bit_if.sv
// seq_divider_8bit_if: request/result bundle of the sequential divider
//   start, dividend, divisor                          : requester -> divider
//   busy, done, quotient, remainder, div_by_zero      : divider -> requester
//   modport master : requester side, modport slave : divider side
interface seq_divider_8bit_if import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH_DEFAULT);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_8bit_step_counter.sv
// div_step_counter: iteration counter for the divider, saturating at WIDTH-1
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous return to zero (wins over enable)
//   enable     : advance by one per edge while below WIDTH-1
//   count      : current iteration index
//   last       : count == WIDTH-1, i.e. the current iteration is the final one
module div_step_counter import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH_DEFAULT,
    parameter int CNT_W = DIV_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             last
);
    assign last = count == CNT_W'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !last)
            count <= count + CNT_W'(1);
endmodule

// File: rtl/seq_divider_8bit.sv
// seq_divider_8bit: restoring divider producing one quotient bit per clock
//   clk, rst_n : clock, asynchronous active-low reset
//   bus (slave): start/dividend/divisor in; busy/done/quotient/remainder/div_by_zero out
module seq_divider_8bit import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH_DEFAULT,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_divider_8bit_if.slave   bus
);
    div_state_t       state, state_nxt;
    logic [WIDTH-1:0] dreg, quo, q_r, r_r;
    logic [WIDTH:0]   prem, shifted, trial, step_r;
    logic [WIDTH-1:0] step_q;
    logic [CNT_W-1:0] step_cnt;
    logic             dbz_r, last, accept, div_zero;

    assign accept   = state == IDLE && bus.start;
    assign div_zero = bus.divisor == '0;

    div_step_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (state == CALC),
        .count  (step_cnt),
        .last   (last)
    );

    // Partial remainder is WIDTH+1 bits so the trial subtraction's MSB is its sign.
    assign shifted = {prem[WIDTH-1:0], quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, dreg};
    assign step_r  = trial[WIDTH] ? shifted : trial;
    assign step_q  = {quo[WIDTH-2:0], ~trial[WIDTH]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = div_zero ? DONE : CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results are loaded on the edge entering DONE so they are valid with done.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            dreg  <= '0;
            quo   <= '0;
            prem  <= '0;
            q_r   <= '0;
            r_r   <= '0;
            dbz_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dreg  <= bus.divisor;
                quo   <= bus.dividend;
                prem  <= '0;
                dbz_r <= div_zero;
                if (div_zero) begin
                    q_r <= '1;
                    r_r <= bus.dividend;
                end
            end else if (state == CALC) begin
                quo  <= step_q;
                prem <= step_r;
                if (last) begin
                    q_r <= step_q;
                    r_r <= step_r[WIDTH-1:0];
                end
            end
        end

    assign bus.busy        = state != IDLE;
    assign bus.done        = state == DONE;
    assign bus.quotient    = q_r;
    assign bus.remainder   = r_r;
    assign bus.div_by_zero = dbz_r;

    a_last_step: assert property (@(posedge clk) disable iff (!rst_n)
        (state == CALC && step_cnt == CNT_W'(WIDTH - 1)) |=> state == DONE);
endmodule
